// File: rtl/mc_controller.sv
// mc_controller: control FSM for a multicycle MIPS-subset datapath.
// States are decoded straight into the datapath strobes and selects.
// Optional feature: define MC_TIMEOUT_EN to bound every memory wait to
// TIMEOUT cycles and enter a sticky FAULT state when the bound runs out.
module mc_controller #(
    parameter int TIMEOUT = 16,
    parameter int TCNT_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_write,
    output logic        reg_write,
    output logic        iord,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        alu_src_a,
    output logic        branch,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [2:0]  alucontrol,
    output logic [2:0]  branchcontrol,
    output logic        illegal,
    output logic        fault
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC,
        ALUWB,
        BRANCH,
        ADDIEX,
        ADDIWB,
        JUMP,
        FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_q;
    logic        isLoad_q;
    logic        isBne_q;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        timeoutHit;
    logic        unusedInstr;

    assign opcode      = instr[31:26];
    assign funct       = instr[5:0];
    assign unusedInstr = ^instr[25:6];

`ifdef MC_TIMEOUT_EN
    localparam logic [TCNT_W-1:0] CNT_LAST = TCNT_W'(TIMEOUT - 1);

    logic [TCNT_W-1:0] waitCnt_q;
    logic              inWait;

    assign inWait     = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    // A ready in the terminal cycle completes the access instead of faulting.
    assign timeoutHit = inWait && !mem_ready && (waitCnt_q == CNT_LAST);

    // Count consecutive not-ready cycles of the current wait; any exit clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt_q <= '0;
        end else if (inWait && !mem_ready && !timeoutHit) begin
            waitCnt_q <= waitCnt_q + 1'b1;
        end else begin
            waitCnt_q <= '0;
        end
    end

    assign fault = (state_q == FAULT);
`else
    logic unusedCfg;

    assign timeoutHit = 1'b0;
    assign fault      = 1'b0;
    assign unusedCfg  = (TIMEOUT > 0) ^ (TCNT_W > 0);
`endif

    // State sequencing; load/store and beq/bne are latched in DECODE so later
    // states ignore whatever the instruction register holds by then.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            isLoad_q <= 1'b0;
            isBne_q  <= 1'b0;
        end else if (timeoutHit) begin
            state_q <= FAULT;
        end else begin
            case (state_q)
                FETCH: begin
                    if (mem_ready) begin
                        state_q <= DECODE;
                    end
                end
                DECODE: begin
                    isLoad_q <= (opcode == OP_LW);
                    isBne_q  <= (opcode == OP_BNE);
                    case (opcode)
                        OP_LW, OP_SW:   state_q <= MEMADR;
                        OP_RTYPE:       state_q <= EXEC;
                        OP_BEQ, OP_BNE: state_q <= BRANCH;
                        OP_ADDI:        state_q <= ADDIEX;
                        OP_J:           state_q <= JUMP;
                        default:        state_q <= FETCH;
                    endcase
                end
                MEMADR:  state_q <= isLoad_q ? MEMRD : MEMWR;
                MEMRD: begin
                    if (mem_ready) begin
                        state_q <= MEMWB;
                    end
                end
                MEMWB:   state_q <= FETCH;
                MEMWR: begin
                    if (mem_ready) begin
                        state_q <= FETCH;
                    end
                end
                EXEC:    state_q <= ALUWB;
                ALUWB:   state_q <= FETCH;
                BRANCH:  state_q <= FETCH;
                ADDIEX:  state_q <= ADDIWB;
                ADDIWB:  state_q <= FETCH;
                JUMP:    state_q <= FETCH;
                FAULT:   state_q <= FAULT;
                default: state_q <= FETCH;
            endcase
        end
    end

    // Moore decode of the current state; reset masks every write strobe and
    // the illegal pulse so nothing is written while the controller restarts.
    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        iord          = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        branch        = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        alucontrol    = 3'b000;
        branchcontrol = 3'b000;
        illegal       = 1'b0;
        case (state_q)
            FETCH: begin
                alu_src_b  = 2'b01;
                alucontrol = 3'b010;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_b  = 2'b11;
                alucontrol = 3'b010;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_ADDI, OP_J: illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR, ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alucontrol = 3'b010;
            end
            MEMRD: begin
                iord = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alucontrol    = 3'b110;
                branch        = 1'b1;
                pc_src        = 2'b01;
                branchcontrol = isBne_q ? 3'b010 : 3'b001;
            end
            ADDIWB: begin
                reg_write = 1'b1;
            end
            JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench for mc_controller.
// Each stimulus cycle queues the hand-derived output vector for that cycle;
// a negedge monitor pops and compares. Define MC_TIMEOUT_EN for fault tests.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_write, mem_write, reg_write;
    logic        iord, mem_to_reg, reg_dst, alu_src_a, branch;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alucontrol, branchcontrol;
    logic        illegal, fault;
    logic [20:0] got;

    int total = 0;
    int bad = 0;

    logic [20:0] expQ[$];
    string       nameQ[$];

    // Vector layout: {pc_write, ir_write, mem_write, reg_write,
    //                 iord, mem_to_reg, reg_dst, alu_src_a, branch,
    //                 alu_src_b, pc_src, alucontrol, branchcontrol, illegal, fault}
    localparam logic [20:0] E_FETCH_W  = {4'b0000, 5'b00000, 2'b01, 2'b00, 3'b010, 3'b000, 2'b00};
    localparam logic [20:0] E_FETCH_GO = {4'b1100, 5'b00000, 2'b01, 2'b00, 3'b010, 3'b000, 2'b00};
    localparam logic [20:0] E_DECODE   = {4'b0000, 5'b00000, 2'b11, 2'b00, 3'b010, 3'b000, 2'b00};
    localparam logic [20:0] E_DEC_ILL  = {4'b0000, 5'b00000, 2'b11, 2'b00, 3'b010, 3'b000, 2'b10};
    localparam logic [20:0] E_MEMADR   = {4'b0000, 5'b00010, 2'b10, 2'b00, 3'b010, 3'b000, 2'b00};
    localparam logic [20:0] E_MEMRD    = {4'b0000, 5'b10000, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
    localparam logic [20:0] E_MEMWB    = {4'b0001, 5'b01000, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
    localparam logic [20:0] E_MEMWR    = {4'b0010, 5'b10000, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
    localparam logic [20:0] E_ALUWB    = {4'b0001, 5'b00100, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
    localparam logic [20:0] E_BEQ      = {4'b0000, 5'b00011, 2'b00, 2'b01, 3'b110, 3'b001, 2'b00};
    localparam logic [20:0] E_BNE      = {4'b0000, 5'b00011, 2'b00, 2'b01, 3'b110, 3'b010, 2'b00};
    localparam logic [20:0] E_ADDIWB   = {4'b0001, 5'b00000, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00};
    localparam logic [20:0] E_JUMP     = {4'b1000, 5'b00000, 2'b00, 2'b10, 3'b000, 3'b000, 2'b00};
    localparam logic [20:0] E_FAULT    = {4'b0000, 5'b00000, 2'b00, 2'b00, 3'b000, 3'b000, 2'b01};

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_LW   = 32'h8C220004;
    localparam logic [31:0] I_SW   = 32'hAC220004;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_BNE  = 32'h14220003;
    localparam logic [31:0] I_ADDI = 32'h20220005;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_ILL  = 32'hFC000000;

    always #5 clk = ~clk;

    mc_controller #(
        .TIMEOUT (4),
        .TCNT_W  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .ir_write      (ir_write),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .iord          (iord),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .alu_src_a     (alu_src_a),
        .branch        (branch),
        .alu_src_b     (alu_src_b),
        .pc_src        (pc_src),
        .alucontrol    (alucontrol),
        .branchcontrol (branchcontrol),
        .illegal       (illegal),
        .fault         (fault)
    );

    assign got = {pc_write, ir_write, mem_write, reg_write,
                  iord, mem_to_reg, reg_dst, alu_src_a, branch,
                  alu_src_b, pc_src, alucontrol, branchcontrol, illegal, fault};

    function automatic logic [20:0] execVec(input logic [2:0] aluc);
        return {4'b0000, 5'b00010, 2'b00, 2'b00, aluc, 3'b000, 2'b00};
    endfunction

    // Drive one cycle of inputs just after the edge and queue its expected outputs.
    task automatic applyStimulus(input logic r, input logic [31:0] ins, input logic mr,
                                 input logic [20:0] e, input string nm);
        @(posedge clk);
        #1;
        reset     = r;
        instr     = ins;
        mem_ready = mr;
        expQ.push_back(e);
        nameQ.push_back(nm);
    endtask

    task automatic checkOutput(input logic [20:0] e, input string nm);
        total++;
        if (got !== e) begin
            bad++;
            $display("[TB] FAIL %s: got %06h expected %06h", nm, got, e);
        end
    endtask

    task automatic rType(input logic [31:0] ins, input logic [2:0] aluc, input string nm);
        applyStimulus(1'b0, ins, 1'b1, E_FETCH_GO, {nm, " fetch"});
        applyStimulus(1'b0, ins, 1'b1, E_DECODE, {nm, " decode"});
        applyStimulus(1'b0, ins, 1'b1, execVec(aluc), {nm, " exec"});
        applyStimulus(1'b0, 32'hFFFFFFFF, 1'b1, E_ALUWB, {nm, " aluwb"});
    endtask

    // Monitor: the controller presents a full output vector every cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front(), nameQ.pop_front());
        end
    end

    initial begin
        logic [31:0] rIns[6];
        logic [2:0]  rAlu[6];
        rIns = '{32'h00221820, 32'h00221822, 32'h00221824,
                 32'h00221825, 32'h0022182A, 32'h00221807};
        rAlu = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};

        $display("[TB] start");
        applyStimulus(1'b1, I_ADD, 1'b1, E_FETCH_W, "reset fetch masked");

        for (int i = 0; i < 6; i++) begin
            rType(rIns[i], rAlu[i], $sformatf("rtype%0d", i));
        end

        applyStimulus(1'b0, I_LW, 1'b1, E_FETCH_GO, "lw fetch");
        applyStimulus(1'b0, I_LW, 1'b1, E_DECODE, "lw decode");
        applyStimulus(1'b0, I_ILL, 1'b1, E_MEMADR, "lw memadr");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, I_SW, 1'b0, E_MEMRD, "lw memrd wait");
        end
        applyStimulus(1'b0, I_SW, 1'b1, E_MEMRD, "lw memrd done");
        applyStimulus(1'b0, I_SW, 1'b1, E_MEMWB, "lw memwb");

        applyStimulus(1'b0, I_SW, 1'b1, E_FETCH_GO, "sw fetch");
        applyStimulus(1'b0, I_SW, 1'b1, E_DECODE, "sw decode");
        applyStimulus(1'b0, I_LW, 1'b1, E_MEMADR, "sw memadr");
        applyStimulus(1'b0, I_LW, 1'b0, E_MEMWR, "sw memwr wait");
        applyStimulus(1'b0, I_LW, 1'b1, E_MEMWR, "sw memwr done");

        applyStimulus(1'b0, I_BEQ, 1'b0, E_FETCH_W, "beq fetch wait");
        applyStimulus(1'b0, I_BEQ, 1'b0, E_FETCH_W, "beq fetch wait");
        applyStimulus(1'b0, I_BEQ, 1'b1, E_FETCH_GO, "beq fetch");
        applyStimulus(1'b0, I_BEQ, 1'b1, E_DECODE, "beq decode");
        applyStimulus(1'b0, I_BEQ, 1'b1, E_BEQ, "beq branch");

        applyStimulus(1'b0, I_BNE, 1'b1, E_FETCH_GO, "bne fetch");
        applyStimulus(1'b0, I_BNE, 1'b1, E_DECODE, "bne decode");
        applyStimulus(1'b0, I_BEQ, 1'b1, E_BNE, "bne branch");

        applyStimulus(1'b0, I_ILL, 1'b1, E_FETCH_GO, "ill fetch");
        applyStimulus(1'b0, I_ILL, 1'b1, E_DEC_ILL, "ill decode pulse");
        applyStimulus(1'b0, I_ILL, 1'b1, E_FETCH_GO, "ill back to fetch");
        applyStimulus(1'b1, I_ILL, 1'b1, E_DECODE, "ill decode under reset");
        applyStimulus(1'b0, I_J, 1'b1, E_FETCH_GO, "j fetch");
        applyStimulus(1'b0, I_J, 1'b1, E_DECODE, "j decode");
        applyStimulus(1'b0, I_J, 1'b1, E_JUMP, "j jump");

        applyStimulus(1'b0, I_SW, 1'b1, E_FETCH_GO, "sw2 fetch");
        applyStimulus(1'b0, I_SW, 1'b1, E_DECODE, "sw2 decode");
        applyStimulus(1'b0, I_SW, 1'b1, E_MEMADR, "sw2 memadr");
        applyStimulus(1'b0, I_SW, 1'b0, E_MEMWR, "sw2 memwr");
        applyStimulus(1'b1, I_SW, 1'b0, E_MEMRD, "sw2 memwr reset masked");
        applyStimulus(1'b0, I_ADDI, 1'b1, E_FETCH_GO, "addi fetch after reset");
        applyStimulus(1'b0, I_ADDI, 1'b1, E_DECODE, "addi decode");
        applyStimulus(1'b0, I_ADDI, 1'b1, E_MEMADR, "addi addiex");
        applyStimulus(1'b0, I_ADDI, 1'b1, E_ADDIWB, "addi addiwb");

`ifdef MC_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, I_J, 1'b0, E_FETCH_W, "timeout fetch wait");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, I_J, 1'b1, E_FAULT, "fault sticky");
        end
        applyStimulus(1'b1, I_J, 1'b1, E_FAULT, "fault during reset");
        applyStimulus(1'b0, I_J, 1'b1, E_FETCH_GO, "fetch after fault reset");
`else
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, I_J, 1'b0, E_FETCH_W, "fetch long wait");
        end
        applyStimulus(1'b0, I_J, 1'b1, E_FETCH_GO, "fetch after long wait");
`endif

        for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
            @(posedge clk);
        end
        if (expQ.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum wait cycles for mem_ready in any memory-wait state (legal range 2..255).
REQ-002 Parameter: TCNT_W, 8, width of the timeout counter (sized so TIMEOUT-1 fits).
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: instr  in  32  instruction register contents; opcode [31:26], funct [5:0].
REQ-006 Port: mem_ready  in  1  memory handshake; access completes in the cycle it is high.
REQ-007 Port: pc_write, ir_write, mem_write, reg_write  out  1 each  write strobes.
REQ-008 Port: iord, mem_to_reg, reg_dst, alu_src_a, branch  out  1 each  datapath selects.
REQ-009 Port: alu_src_b  out  2  ALU B select: 00 reg, 01 const 4, 10 sign-extended immediate, 11 immediate<<2.
REQ-010 Port: pc_src  out  2  PC select: 00 ALU result, 01 ALU out register, 10 jump target.
REQ-011 Port: alucontrol, branchcontrol  out  3 each  ALU operation; branch condition (001 beq, 010 bne, 000 none).
REQ-012 Port: illegal  out  1  one-cycle pulse on an unrecognised opcode; fault  out  1  sticky memory timeout.

Function
REQ-013 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, FAULT.
REQ-014 FETCH: iord=0, alu_src_a=0, alu_src_b=01, alucontrol=010, pc_src=00; ir_write=pc_write=1 only when mem_ready=1; stays in FETCH while mem_ready=0, else moves to DECODE.
REQ-015 DECODE: alu_src_a=0, alu_src_b=11, alucontrol=010; next state by opcode: 100011/101011->MEMADR, 000000->EXEC, 000100/000101->BRANCH, 001000->ADDIEX, 000010->JUMP, other->FETCH with illegal=1 for that cycle.
REQ-016 MEMADR: alu_src_a=1, alu_src_b=10, alucontrol=010; lw->MEMRD, sw->MEMWR.
REQ-017 MEMRD: iord=1; waits for mem_ready, then ->MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; ->FETCH.
REQ-018 MEMWR: iord=1, mem_write=1 held until the mem_ready cycle inclusive; then ->FETCH.
REQ-019 EXEC: alu_src_a=1, alu_src_b=00; alucontrol from funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other->010; ->ALUWB.
REQ-020 ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-021 BRANCH: alu_src_a=1, alu_src_b=00, alucontrol=110, branch=1, pc_src=01, branchcontrol=001 (beq) or 010 (bne); ->FETCH.
REQ-022 ADDIEX: alu_src_a=1, alu_src_b=10, alucontrol=010; ->ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-023 JUMP: pc_write=1, pc_src=10; ->FETCH.
REQ-024 All outputs not listed for a state are 0; branchcontrol=000 outside BRANCH.
REQ-025 Latency (mem_ready tied high): R-type 4 cycles, lw 5, sw 4, beq/bne 3, addi 4, j 3.
REQ-026 instr sampled only in DECODE and EXEC; changes in other states have no effect.

Reset
REQ-027 reset=1 on a clock edge forces state to FETCH, timeout counter to 0, fault to 0, regardless of current state, including mid-wait.
REQ-028 While reset=1, all write strobes (pc_write, ir_write, mem_write, reg_write) and illegal are forced to 0; first fetch strobe can occur in the first cycle after reset deasserts.

Configuration
REQ-029 Macro MC_TIMEOUT_EN defined: counter increments each cycle in FETCH/MEMRD/MEMWR with mem_ready=0, clears on mem_ready=1 or state change; reaching TIMEOUT-1 with mem_ready=0 moves to FAULT.
REQ-030 FAULT: all strobes 0, fault=1, remains until reset; mem_ready=1 in the terminal cycle wins over timeout.
REQ-031 Macro undefined: no counter, FAULT unreachable, fault tied 0, wait states wait indefinitely.

Verification
REQ-032 Reset, mem_ready=1, instr=0x00221820 (add) -> states FETCH,DECODE,EXEC,ALUWB; alucontrol=010 in EXEC; reg_write=1, reg_dst=1 in ALUWB.
REQ-033 instr=0x8C220004 (lw), mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, iord=1 throughout, then MEMWB with mem_to_reg=1.
REQ-034 instr=0x14220003 (bne) -> BRANCH cycle with branchcontrol=010, pc_src=01, alucontrol=110.
REQ-035 instr=0xFC000000 -> illegal=1 for exactly one cycle in DECODE, next state FETCH, no write strobe.
REQ-036 MC_TIMEOUT_EN, TIMEOUT=4, mem_ready=0 in FETCH -> FAULT after 4 cycles, fault=1 held; reset -> FETCH, fault=0.
REQ-037 reset asserted during MEMWR with mem_write=1 -> mem_write=0 in that cycle, FETCH next.
